// File: rtl/posit_to_fp32_8_es3.sv
// Three-stage decoder from an 8-bit es=3 posit to IEEE-754 binary32.
// Every such posit is exact in binary32, so the datapath has no rounding.
module posit_to_fp32_8_es3 #(
  parameter int NBITS   = 8,
  parameter int ES      = 3,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in1,
  input  logic        start,
  output logic [31:0] result,
  output logic        nar,
  output logic        zero,
  output logic        done
);

  // Handshake: start marks in1 valid for one conversion in that cycle; done
  // pulses exactly once, LATENCY cycles later, with result/nar/zero valid.
  // There is no backpressure and no reordering.

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Leading-one detector: {found, position of the most significant 1}.
  function automatic logic [3:0] lod_n(input logic [6:0] x);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 7; i++) begin
      if (x[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // S0: operand capture and the valid shift register that becomes done.
  logic [NBITS-1:0]   in_q;
  logic [LATENCY-1:0] vld_sr;
  logic [31-NBITS:0]  unused_in_hi;

  assign unused_in_hi = in1[31:NBITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      vld_sr <= '0;
    end else begin
      in_q   <= in1[NBITS-1:0];
      vld_sr <= {vld_sr[LATENCY-2:0], (start === 1'b1)};
    end
  end

  // Decode: regime run length via LOD, then exponent and fraction follow it.
  logic          sgn_d;
  logic [6:0]    abs7;
  logic          run_bit;
  logic [6:0]    lod_in;
  logic [3:0]    lod_out;
  logic [2:0]    run_len;
  logic [3:0]    shamt;
  logic [6:0]    rem;
  logic [ES-1:0] e_d;
  logic [3:0]    frac_d;
  logic [3:0]    k_d;
  logic [8:0]    scale_d;

  always_comb begin
    sgn_d   = in_q[NBITS-1];
    abs7    = sgn_d ? (~in_q[6:0] + 7'd1) : in_q[6:0];
    run_bit = abs7[6];
    lod_in  = run_bit ? ~abs7 : abs7;
    lod_out = lod_n(lod_in);
    run_len = lod_out[3] ? (3'd6 - lod_out[2:0]) : 3'd7;
    shamt   = {1'b0, run_len} + 4'd1;
    rem     = abs7 << shamt;
    e_d     = rem[6 -: ES];
    frac_d  = rem[6-ES:0];
    k_d     = run_bit ? ({1'b0, run_len} - 4'd1) : (4'd0 - {1'b0, run_len});
    scale_d = {{(9-4-ES){k_d[3]}}, k_d, {ES{1'b0}}} + 9'(e_d);
  end

  // S1: decoded fields.
  logic       sgn1;
  logic [8:0] scale1;
  logic [3:0] frac1;
  logic       zero1;
  logic       nar1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn1   <= 1'b0;
      scale1 <= '0;
      frac1  <= '0;
      zero1  <= 1'b0;
      nar1   <= 1'b0;
    end else begin
      sgn1   <= sgn_d;
      scale1 <= scale_d;
      frac1  <= frac_d;
      zero1  <= (in_q == '0);
      nar1   <= (in_q == {1'b1, {(NBITS-1){1'b0}}});
    end
  end

  // Pack: biased exponent always lands in [79,175], so bit 8 is always 0.
  logic       unused_exp_msb;
  logic [7:0] exp8;
  logic       v1;

  assign {unused_exp_msb, exp8} = scale1 + 9'd127;
  assign v1 = vld_sr[1];

  // S2: packed result; bubbles carry all-zero data and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      nar    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      nar  <= v1 & nar1;
      zero <= v1 & zero1;
      if (!v1 || zero1)
        result <= '0;
      else if (nar1)
        result <= QNAN;
      else
        result <= {sgn1, exp8, frac1, 19'd0};
    end
  end

  assign done = vld_sr[LATENCY-1];

endmodule

// File: tb/tb_posit_to_fp32_8_es3.sv
// Bench for posit_to_fp32_8_es3: directed vectors and a full sweep, checked
// by a queue-based scoreboard against hand values and a bit-serial model.
module tb_posit_to_fp32_8_es3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in1 = '0;
  logic        start = 1'b0;
  logic [31:0] result;
  logic        nar;
  logic        zero;
  logic        done;

  posit_to_fp32_8_es3 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in1    (in1),
    .start  (start),
    .result (result),
    .nar    (nar),
    .zero   (zero),
    .done   (done)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];     // {nar, zero, result}
  int          exp_cyc_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Bit-serial reference: walks the posit one bit at a time.
  function automatic logic [31:0] ref_fp(input logic [7:0] p);
    logic [7:0]  a;
    logic        s;
    logic        b;
    logic [22:0] m;
    int          i;
    int          r;
    int          k;
    int          e;
    int          pos;
    int          ex;
    if (p == 8'h00) return 32'h0000_0000;
    if (p == 8'h80) return 32'h7FC0_0000;
    s = p[7];
    a = s ? (8'd0 - p) : p;
    b = a[6];
    i = 6;
    r = 0;
    while (i >= 0 && a[i] == b) begin
      r++;
      i--;
    end
    i--;
    k = b ? r - 1 : -r;
    e = 0;
    for (int j = 0; j < 3; j++) begin
      e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    m = '0;
    pos = 22;
    while (i >= 0) begin
      m[pos] = a[i];
      pos--;
      i--;
    end
    ex = 8 * k + e + 127;
    return {s, 8'(ex), m};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] v, input logic [31:0] res, input logic n, input logic z);
    in1   = v;
    start = 1'b1;
    exp_q.push_back({n, z, res});
    exp_cyc_q.push_back(cyc + 3);
  endtask

  task automatic single(input logic [31:0] v, input logic [31:0] res, input logic n, input logic z);
    issue(v, res, n, z);
    tick();
    start = 1'b0;
    repeat (4) tick();
  endtask

  task automatic issue_model(input logic [7:0] p);
    issue({24'h0, p}, ref_fp(p), p == 8'h80, p == 8'h00);
  endtask

  task automatic pulse_reset();
    start = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check("reset_async_outputs", {28'd0, done, nar, zero, 1'b0, result},
          {28'd0, 3'b000, 1'b0, 32'h0});
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    int          ec;
    if (!rst_n) begin
      check("reset_outputs", {28'd0, done, nar, zero, 1'b0, result}, 64'h0);
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'h0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", {30'd0, nar, zero, result}, {30'd0, e});
        check("latency", 64'(cyc), 64'(ec));
      end
    end else begin
      check("idle_flags", {62'd0, nar, zero}, 64'h0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    rst_n = 1'b0;
    start = 1'b1;
    in1   = 32'h0000_0040;
    repeat (5) tick();
    rst_n = 1'b1;
    start = 1'b0;
    repeat (5) tick();

    single(32'h0000_0040, 32'h3F80_0000, 1'b0, 1'b0);
    single(32'h0000_0048, 32'h4080_0000, 1'b0, 1'b0);
    single(32'h0000_0041, 32'h3FA0_0000, 1'b0, 1'b0);
    single(32'h0000_00C0, 32'hBF80_0000, 1'b0, 1'b0);
    single(32'h0000_007F, 32'h5780_0000, 1'b0, 1'b0);
    single(32'h0000_0001, 32'h2780_0000, 1'b0, 1'b0);
    single(32'h0000_0081, 32'hD780_0000, 1'b0, 1'b0);
    single(32'h0000_00FF, 32'hA780_0000, 1'b0, 1'b0);
    single(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    single(32'h0000_0080, 32'h7FC0_0000, 1'b1, 1'b0);
    single(32'hABCD_0040, 32'h3F80_0000, 1'b0, 1'b0);

    for (int i = 0; i < 100; i++) begin
      issue_model(8'(i));
      tick();
    end
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      issue_model(8'(i));
      tick();
    end
    start = 1'b0;

    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      tick();
      budget++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'h0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
